// File: rtl/fsm_test.sv
// fsm_test: arm-on-start, trigger a fixed delay after the next fast-gate rising edge, then hold off.
// Revision 1.0 - initial release.
`default_nettype none

module fsm_test #(
  parameter int FG_DELAY_CYCLES   = 400_000,
  parameter int TRIG_WIDTH_CYCLES = 2_000,
  parameter int HOLDOFF_CYCLES    = 1_280_000
) (
  input  logic clock,
  input  logic reset,
  input  logic start_signal,
  input  logic fg_signal,
  output logic detector_trigger
);

  localparam int MAX_A  = (FG_DELAY_CYCLES > TRIG_WIDTH_CYCLES) ? FG_DELAY_CYCLES : TRIG_WIDTH_CYCLES;
  localparam int MAX_P  = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int CNT_W  = ($clog2(MAX_P + 1) > 21) ? $clog2(MAX_P + 1) : 21;

  localparam logic [CNT_W-1:0] LOAD_DELAY   = CNT_W'(FG_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_TRIG    = CNT_W'(TRIG_WIDTH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_HOLDOFF = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FG = 3'd1,
    DELAY   = 3'd2,
    TRIGGER = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;

  logic start_meta_q, start_sync_q, start_dly_q;
  logic fg_meta_q, fg_sync_q, fg_dly_q;
  logic start_rise, fg_rise;
  logic cnt_zero;

  // Two-flop synchronizers followed by one delay flop for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_dly_q  <= 1'b0;
      fg_meta_q    <= 1'b0;
      fg_sync_q    <= 1'b0;
      fg_dly_q     <= 1'b0;
    end else begin
      start_meta_q <= start_signal;
      start_sync_q <= start_meta_q;
      start_dly_q  <= start_sync_q;
      fg_meta_q    <= fg_signal;
      fg_sync_q    <= fg_meta_q;
      fg_dly_q     <= fg_sync_q;
    end
  end

  assign start_rise = start_sync_q & ~start_dly_q;
  assign fg_rise    = fg_sync_q & ~fg_dly_q;
  assign cnt_zero   = (cnt_q == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_rise) state_d = WAIT_FG;
      end
      WAIT_FG: begin
        if (fg_rise) begin
          cnt_d   = LOAD_DELAY;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (cnt_zero) begin
          cnt_d   = LOAD_TRIG;
          state_d = TRIGGER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TRIGGER: begin
        if (cnt_zero) begin
          cnt_d   = LOAD_HOLDOFF;
          state_d = HOLDOFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_zero) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Decoding the next state keeps the output aligned with the TRIGGER dwell itself.
  assign trig_d           = (state_d == TRIGGER);
  assign detector_trigger = trig_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_test.sv
// tb_fsm_test: three parameterizations driven by common random/directed stimulus, checked against an interval model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_fsm_test;

  localparam int NI = 3;
  localparam int D_P [NI] = '{6, 3, 1};
  localparam int T_P [NI] = '{4, 3, 1};
  localparam int H_P [NI] = '{8, 3, 1};

  logic       clock;
  logic       reset;
  logic       start_signal;
  logic       fg_signal;
  logic [2:0] trig;

  int n_total = 0;
  int n_pass  = 0;
  int n_edge  = 0;

  // Sampled-input history: bit0 = previous edge, bit1 = two edges ago, bit2 = three edges ago.
  logic [2:0] s_hist = '0;
  logic [2:0] f_hist = '0;
  int         mode   [NI];
  int         lo     [NI];
  int         hi     [NI];
  int         idle_at[NI];
  logic [2:0] exp_trig = '0;

  fsm_test #(.FG_DELAY_CYCLES(6), .TRIG_WIDTH_CYCLES(4), .HOLDOFF_CYCLES(8)) u_dut0 (
    .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
    .detector_trigger(trig[0])
  );
  fsm_test #(.FG_DELAY_CYCLES(3), .TRIG_WIDTH_CYCLES(3), .HOLDOFF_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
    .detector_trigger(trig[1])
  );
  fsm_test #(.FG_DELAY_CYCLES(1), .TRIG_WIDTH_CYCLES(1), .HOLDOFF_CYCLES(1)) u_dut2 (
    .clock(clock), .reset(reset), .start_signal(start_signal), .fg_signal(fg_signal),
    .detector_trigger(trig[2])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_bit(input string tag, input logic got, input logic want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s edge=%0d got=%b want=%b", tag, n_edge, got, want);
  endtask

  // Mode 0: idle, 1: armed waiting for fg edge, 2: sequence scheduled as absolute edge intervals.
  task automatic model_edge(input logic r, input logic s, input logic f);
    logic srise, frise;
    srise = s_hist[1] & ~s_hist[2];
    frise = f_hist[1] & ~f_hist[2];
    for (int i = 0; i < NI; i++) begin
      if (!r) begin
        mode[i] = 0;
      end else begin
        case (mode[i])
          0: if (srise) mode[i] = 1;
          1: if (frise) begin
               lo[i]      = n_edge + D_P[i];
               hi[i]      = n_edge + D_P[i] + T_P[i] - 1;
               idle_at[i] = n_edge + D_P[i] + T_P[i] + H_P[i];
               mode[i]    = 2;
             end
          default: if (n_edge == idle_at[i]) mode[i] = 0;
        endcase
      end
      exp_trig[i] = (mode[i] == 2) && (n_edge >= lo[i]) && (n_edge <= hi[i]);
    end
    if (!r) begin
      s_hist = '0;
      f_hist = '0;
    end else begin
      s_hist = {s_hist[1:0], s};
      f_hist = {f_hist[1:0], f};
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f);
    @(negedge clock);
    for (int i = 0; i < NI; i++) check_bit($sformatf("trig%0d", i), trig[i], exp_trig[i]);
    n_edge++;
    model_edge(r, s, f);
    reset        = r;
    start_signal = s;
    fg_signal    = f;
  endtask

  task automatic idle_cycles(input int k, input logic f);
    for (int j = 0; j < k; j++) step(1'b1, 1'b0, f);
  endtask

  task automatic fg_pulse(input int w);
    for (int j = 0; j < w; j++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int fg_ph, fg_per, fg_w, s_left;
    logic r, s, f;
    for (int i = 0; i < NI; i++) begin
      mode[i] = 0; lo[i] = 0; hi[i] = 0; idle_at[i] = 0;
    end
    reset = 1'b0; start_signal = 1'b0; fg_signal = 1'b0;

    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b0);

    // fg only, never armed
    for (int j = 0; j < 5; j++) begin fg_pulse(2); idle_cycles(12, 1'b0); end

    // nominal arm then fg edge
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    idle_cycles(5, 1'b0); fg_pulse(2); idle_cycles(40, 1'b0);

    // start accepted while fg already high: only the next fg edge counts
    idle_cycles(3, 1'b1);
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
    idle_cycles(6, 1'b1); idle_cycles(6, 1'b0);
    fg_pulse(1); idle_cycles(40, 1'b0);

    // start and fg edges coincide
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
    idle_cycles(6, 1'b0); fg_pulse(3); idle_cycles(40, 1'b0);

    // repeated starts and fg edges during the sequence
    step(1'b1, 1'b1, 1'b0); idle_cycles(4, 1'b0); fg_pulse(1);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
    end
    idle_cycles(40, 1'b0);

    // one-cycle reset during instance 0's trigger window
    step(1'b1, 1'b1, 1'b0); idle_cycles(4, 1'b0); fg_pulse(1);
    idle_cycles(D_P[0] + 1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle_cycles(10, 1'b0); fg_pulse(2); idle_cycles(40, 1'b0);

    // reset release with inputs already high registers as rising edges
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle_cycles(6, 1'b0); fg_pulse(1); idle_cycles(40, 1'b0);

    fg_ph = 0; fg_per = 20; fg_w = 2; s_left = 0;
    for (int c = 0; c < 6000; c++) begin
      f = (fg_ph < fg_w);
      fg_ph++;
      if (fg_ph >= fg_per) begin
        fg_ph  = 0;
        fg_per = $urandom_range(10, 40);
        fg_w   = $urandom_range(1, 4);
      end
      if (s_left > 0) begin
        s = 1'b1; s_left--;
      end else begin
        s = 1'b0;
        if ($urandom_range(0, 29) == 0) s_left = $urandom_range(1, 4);
      end
      r = ($urandom_range(0, 249) != 0);
      step(r, s, f);
    end
    step(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
